// File: rtl/filter_win_pkg.sv
// filter_win_pkg: shared state type and sizing helpers for filter_win_nxn.
// Build option FILTER_WIN_REPLICATE_EN selects border replication over zero pad.
package filter_win_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int win_r(input int win);
    return (win - 1) / 2;
  endfunction

  function automatic int flush_d(input int win, input int w);
    return win_r(win) * w + win_r(win);
  endfunction

endpackage

// File: rtl/filter_win_nxn_line_buf.sv
// line_buf_ram: one-line pixel delay, 1 write + 1 read per cycle.
// Read is combinational at the write address, so it returns the old word.
module line_buf_ram
  import filter_win_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 640,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/filter_win_nxn.sv
// filter_win_nxn: NxN sliding window with border padding and self-flush.
// Define FILTER_WIN_REPLICATE_EN for edge replication; default is zero pad.
module filter_win_nxn
  import filter_win_pkg::*;
#(
  parameter int DW    = 8,
  parameter int WIN   = 3,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iValid,
  input  logic                  iSof,
  input  logic [DW-1:0]         iData,
  output logic                  oReady,
  output logic                  oValid,
  output logic                  oSof,
  output logic                  oEof,
  output logic [WIN*WIN*DW-1:0] oWin
);

  localparam int R  = win_r(WIN);
  localparam int D  = flush_d(WIN, IMG_W);
  localparam int CW = clog2(IMG_W);
  localparam int RW = clog2(IMG_H);
  localparam int LW = clog2(D + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [LW-1:0] LEAD_MAX = LW'(D);
  localparam logic [LW-1:0] FL_LAST = LW'(D - 1);

  state_t state, state_n;
  logic [CW-1:0] in_col, slot_col, oc, s1_col;
  logic [RW-1:0] in_row, orow, s1_row;
  logic [LW-1:0] lead, fcnt;
  logic accept, start, restart, slot, last_px, emit;
  logic s1_valid, s1_sof, s1_eof;
  logic [DW-1:0] slot_data;
  logic [DW-1:0] rd [WIN-1];
  logic [DW-1:0] wr [WIN-1];
  logic [DW-1:0] col_in [WIN];
  logic [DW-1:0] win [WIN][WIN];
  logic [WIN*WIN*DW-1:0] pad;

  assign oReady    = (state != FLUSH);
  assign accept    = iValid && oReady;
  assign start     = accept && iSof;
  assign restart   = start && (state == RUN);
  assign slot      = (state == FLUSH) || start || (accept && state == RUN);
  assign slot_col  = start ? '0 : in_col;
  assign slot_data = (state == FLUSH) ? '0 : iData;
  assign emit      = slot && !start && (lead == LEAD_MAX);
  assign last_px   = accept && !iSof && (state == RUN) &&
                     (in_col == COL_MAX) && (in_row == ROW_MAX);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_px) state_n = FLUSH;
      FLUSH:   if (fcnt == FL_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col <= '0;
      in_row <= '0;
      lead   <= '0;
      fcnt   <= '0;
      oc     <= '0;
      orow   <= '0;
    end else begin
      fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
      if (slot) begin
        in_col <= (slot_col == COL_MAX) ? '0 : slot_col + 1'b1;
        if (start) in_row <= '0;
        else if (in_col == COL_MAX)
          in_row <= (in_row == ROW_MAX) ? '0 : in_row + 1'b1;
        if (start) lead <= LW'(1);
        else if (lead != LEAD_MAX) lead <= lead + 1'b1;
        if (start) begin
          oc   <= '0;
          orow <= '0;
        end else if (emit) begin
          oc <= (oc == COL_MAX) ? '0 : oc + 1'b1;
          if (oc == COL_MAX)
            orow <= (orow == ROW_MAX) ? '0 : orow + 1'b1;
        end
      end
    end
  end

  // Buffer k delays by k+1 lines; the oldest row lands at window row 0.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign wr[k] = slot_data;
    end else begin : g_tail
      assign wr[k] = rd[k-1];
    end
    line_buf_ram #(.DW(DW), .DEPTH(IMG_W), .AW(CW)) u_lb (
      .clk   (clk),
      .we    (slot),
      .addr  (slot_col),
      .wdata (wr[k]),
      .rdata (rd[k])
    );
  end

  for (genvar r = 0; r < WIN; r++) begin : g_col
    if (r == WIN - 1) begin : g_new
      assign col_in[r] = slot_data;
    end else begin : g_old
      assign col_in[r] = rd[WIN-2-r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          win[r][c] <= '0;
    end else if (slot) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][WIN-1] <= col_in[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= emit;
      if (emit) begin
        s1_col <= oc;
        s1_row <= orow;
        s1_sof <= (oc == '0) && (orow == '0);
        s1_eof <= (oc == COL_MAX) && (orow == ROW_MAX);
      end
    end
  end

  always_comb begin
    int rr, cc;
`ifdef FILTER_WIN_REPLICATE_EN
    int tr, tc;
    tr = 0;
    tc = 0;
`endif
    rr = 0;
    cc = 0;
    pad = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        rr = int'(s1_row) + r - R;
        cc = int'(s1_col) + c - R;
`ifdef FILTER_WIN_REPLICATE_EN
        tr = (rr < 0) ? R - int'(s1_row) :
             (rr > IMG_H - 1) ? IMG_H - 1 - int'(s1_row) + R : r;
        tc = (cc < 0) ? R - int'(s1_col) :
             (cc > IMG_W - 1) ? IMG_W - 1 - int'(s1_col) + R : c;
        for (int i = 0; i < WIN; i++)
          for (int j = 0; j < WIN; j++)
            if (i == tr && j == tc)
              pad[(r*WIN+c)*DW +: DW] = win[i][j];
`else
        if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
          pad[(r*WIN+c)*DW +: DW] = win[r][c];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid <= 1'b0;
      oSof   <= 1'b0;
      oEof   <= 1'b0;
      oWin   <= '0;
    end else begin
      oValid <= s1_valid && !restart;
      oSof   <= s1_valid && !restart && s1_sof;
      oEof   <= s1_valid && !restart && s1_eof;
      if (s1_valid && !restart) oWin <= pad;
    end
  end

endmodule

// File: tb/tb_filter_win_nxn.sv
// tb_filter_win_nxn: 3x3/4x3 and 5x5/8x6 windows vs an image-level model.
// Honours FILTER_WIN_REPLICATE_EN for the padding rule.
module tb_filter_win_nxn;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic a_iv, a_isof, a_rdy, a_ov, a_osof, a_oeof;
  logic [7:0] a_id;
  logic [71:0] a_win;
  logic b_iv, b_isof, b_rdy, b_ov, b_osof, b_oeof;
  logic [7:0] b_id;
  logic [199:0] b_win;

  filter_win_nxn #(.DW(DW), .WIN(3), .IMG_W(4), .IMG_H(3)) u_a (
    .clk(clk), .rst_n(rst_n), .iValid(a_iv), .iSof(a_isof), .iData(a_id),
    .oReady(a_rdy), .oValid(a_ov), .oSof(a_osof), .oEof(a_oeof),
    .oWin(a_win));

  filter_win_nxn #(.DW(DW), .WIN(5), .IMG_W(8), .IMG_H(6)) u_b (
    .clk(clk), .rst_n(rst_n), .iValid(b_iv), .iSof(b_isof), .iData(b_id),
    .oReady(b_rdy), .oValid(b_ov), .oSof(b_osof), .oEof(b_oeof),
    .oWin(b_win));

  typedef struct {
    logic [199:0] w;
    logic sof;
    logic eof;
    int cyc;
  } obs_t;

  obs_t qa[$];
  obs_t qb[$];
  int a_low = 0;
  int b_low = 0;
  logic [7:0] img [64];
  int slot_cyc [64];

  always @(negedge clk) begin
    if (a_ov) qa.push_back('{w: 200'(a_win), sof: a_osof, eof: a_oeof, cyc: cyc});
    if (b_ov) qb.push_back('{w: b_win, sof: b_osof, eof: b_oeof, cyc: cyc});
    if (!a_rdy) a_low++;
    if (!b_rdy) b_low++;
  end

  function automatic logic [199:0] ref_win(int n, int w, int h, int p);
    logic [199:0] res;
    int rad, pr, pc, rr, cc;
    res = '0;
    rad = (n - 1) / 2;
    pr = p / w;
    pc = p % w;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        rr = pr + r - rad;
        cc = pc + c - rad;
`ifdef FILTER_WIN_REPLICATE_EN
        rr = (rr < 0) ? 0 : (rr >= h) ? h - 1 : rr;
        cc = (cc < 0) ? 0 : (cc >= w) ? w - 1 : cc;
        res[(r*n+c)*8 +: 8] = img[rr*w+cc];
`else
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          res[(r*n+c)*8 +: 8] = img[rr*w+cc];
`endif
      end
    end
    return res;
  endfunction

  function automatic int slot_of(int s, int npx);
    return (s < npx) ? slot_cyc[s] : slot_cyc[npx-1] + 1 + s - npx;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input int n, input bit gaps, input bit sof);
    for (int i = 0; i < n; i++) begin
      a_iv = 1'b1;
      a_isof = sof && (i == 0);
      a_id = img[i];
      slot_cyc[i] = cyc;
      @(posedge clk);
      #1;
      a_iv = 1'b0;
      a_isof = 1'b0;
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic feed_b(input int n);
    for (int i = 0; i < n; i++) begin
      b_iv = 1'b1;
      b_isof = (i == 0);
      b_id = img[i];
      slot_cyc[i] = cyc;
      @(posedge clk);
      #1;
      b_iv = 1'b0;
      b_isof = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic ramp_img;
    for (int i = 0; i < 12; i++) img[i] = 8'(i + 1);
  endtask

  task automatic test_reset;
    cmp++;
    if ({a_ov, a_osof, a_oeof, a_rdy} !== 4'b0001) begin
      err++;
      $display("FAIL reset_a_ctl: got %b want 0001", {a_ov, a_osof, a_oeof, a_rdy});
    end
    cmp++;
    if (a_win !== '0) begin
      err++;
      $display("FAIL reset_a_win: got %h want 0", a_win);
    end
    cmp++;
    if ({b_ov, b_osof, b_oeof, b_rdy} !== 4'b0001) begin
      err++;
      $display("FAIL reset_b_ctl: got %b want 0001", {b_ov, b_osof, b_oeof, b_rdy});
    end
    cmp++;
    if (b_win !== '0) begin
      err++;
      $display("FAIL reset_b_win: got %h want 0", b_win);
    end
  endtask

  task automatic test_continuous;
    logic [71:0] first_exp;
    logic [199:0] e;
    ramp_img();
`ifdef FILTER_WIN_REPLICATE_EN
    first_exp = {8'd6, 8'd5, 8'd5, 8'd2, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1};
`else
    first_exp = {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    qa.delete();
    a_low = 0;
    feed_a(12, 1'b0, 1'b1);
    settle(20);
    cmp++;
    if (qa.size() != 12) begin
      err++;
      $display("FAIL cont_count: got %0d want 12", qa.size());
    end
    cmp++;
    if (qa.size() == 0 || qa[0].w !== 200'(first_exp)) begin
      err++;
      $display("FAIL cont_first: got %h want %h",
               (qa.size() == 0) ? 72'h0 : qa[0].w[71:0], first_exp);
    end
    for (int k = 0; k < qa.size() && k < 12; k++) begin
      e = ref_win(3, 4, 3, k);
      cmp++;
      if (qa[k].w !== e || qa[k].sof !== (k == 0) || qa[k].eof !== (k == 11)) begin
        err++;
        $display("FAIL cont_win[%0d]: got %h sof%b eof%b want %h sof%b eof%b",
                 k, qa[k].w[71:0], qa[k].sof, qa[k].eof, e[71:0], k == 0, k == 11);
      end
      cmp++;
      if (qa[k].cyc != slot_of(k + 5, 12) + 2) begin
        err++;
        $display("FAIL cont_lat[%0d]: got cyc %0d want %0d",
                 k, qa[k].cyc, slot_of(k + 5, 12) + 2);
      end
    end
    cmp++;
    if (a_low != 5) begin
      err++;
      $display("FAIL cont_ready_low: got %0d cycles want 5", a_low);
    end
  endtask

  task automatic test_gaps;
    logic [199:0] e;
    ramp_img();
    qa.delete();
    a_low = 0;
    feed_a(12, 1'b1, 1'b1);
    settle(20);
    cmp++;
    if (qa.size() != 12) begin
      err++;
      $display("FAIL gap_count: got %0d want 12", qa.size());
    end
    for (int k = 0; k < qa.size() && k < 12; k++) begin
      e = ref_win(3, 4, 3, k);
      cmp++;
      if (qa[k].w !== e || qa[k].sof !== (k == 0) || qa[k].eof !== (k == 11)) begin
        err++;
        $display("FAIL gap_win[%0d]: got %h sof%b eof%b want %h",
                 k, qa[k].w[71:0], qa[k].sof, qa[k].eof, e[71:0]);
      end
      cmp++;
      if (qa[k].cyc != slot_of(k + 5, 12) + 2) begin
        err++;
        $display("FAIL gap_lat[%0d]: got cyc %0d want %0d",
                 k, qa[k].cyc, slot_of(k + 5, 12) + 2);
      end
    end
    cmp++;
    if (a_low != 5) begin
      err++;
      $display("FAIL gap_ready_low: got %0d cycles want 5", a_low);
    end
  endtask

  task automatic test_abort;
    logic [199:0] e;
    int base, neof;
    ramp_img();
    qa.delete();
    feed_a(6, 1'b0, 1'b1);
    feed_a(12, 1'b0, 1'b1);
    settle(20);
    neof = 0;
    foreach (qa[i]) if (qa[i].eof === 1'b1) neof++;
    cmp++;
    if (qa.size() < 12 || neof != 1) begin
      err++;
      $display("FAIL abort_count: got %0d windows %0d eof want >=12 and 1",
               qa.size(), neof);
    end
    base = (qa.size() < 12) ? 0 : qa.size() - 12;
    for (int k = 0; k < 12 && base + k < qa.size(); k++) begin
      e = ref_win(3, 4, 3, k);
      cmp++;
      if (qa[base+k].w !== e || qa[base+k].sof !== (k == 0) ||
          qa[base+k].eof !== (k == 11)) begin
        err++;
        $display("FAIL abort_win[%0d]: got %h sof%b eof%b want %h",
                 k, qa[base+k].w[71:0], qa[base+k].sof, qa[base+k].eof, e[71:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [199:0] e;
    ramp_img();
    feed_a(8, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({a_ov, a_osof, a_oeof, a_rdy} !== 4'b0001 || a_win !== '0) begin
      err++;
      $display("FAIL rstmid_out: got ctl %b win %h want 0001 and 0",
               {a_ov, a_osof, a_oeof, a_rdy}, a_win);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    for (int i = 0; i < 12; i++) img[i] = 8'(8'hA0 + i);
    feed_a(3, 1'b0, 1'b0);
    ramp_img();
    feed_a(12, 1'b0, 1'b1);
    settle(20);
    cmp++;
    if (qa.size() != 12) begin
      err++;
      $display("FAIL rstmid_count: got %0d want 12", qa.size());
    end
    for (int k = 0; k < qa.size() && k < 12; k++) begin
      e = ref_win(3, 4, 3, k);
      cmp++;
      if (qa[k].w !== e || qa[k].sof !== (k == 0) || qa[k].eof !== (k == 11)) begin
        err++;
        $display("FAIL rstmid_win[%0d]: got %h want %h", k, qa[k].w[71:0], e[71:0]);
      end
    end
  endtask

  task automatic test_random_5x5;
    logic [199:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 48; i++) img[i] = 8'($urandom_range(0, 255));
      qb.delete();
      b_low = 0;
      feed_b(48);
      settle(60);
      cmp++;
      if (qb.size() != 48) begin
        err++;
        $display("FAIL rnd_count[%0d]: got %0d want 48", f, qb.size());
      end
      for (int k = 0; k < qb.size() && k < 48; k++) begin
        e = ref_win(5, 8, 6, k);
        cmp++;
        if (qb[k].w !== e || qb[k].sof !== (k == 0) || qb[k].eof !== (k == 47)) begin
          err++;
          $display("FAIL rnd_win[%0d][%0d]: got %h sof%b eof%b want %h",
                   f, k, qb[k].w, qb[k].sof, qb[k].eof, e);
        end
        cmp++;
        if (qb[k].cyc != slot_of(k + 18, 48) + 2) begin
          err++;
          $display("FAIL rnd_lat[%0d][%0d]: got cyc %0d want %0d",
                   f, k, qb[k].cyc, slot_of(k + 18, 48) + 2);
        end
      end
      cmp++;
      if (b_low != 18) begin
        err++;
        $display("FAIL rnd_ready_low[%0d]: got %0d want 18", f, b_low);
      end
    end
  endtask

  initial begin
    a_iv = 1'b0;
    a_isof = 1'b0;
    a_id = '0;
    b_iv = 1'b0;
    b_isof = 1'b0;
    b_id = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_random_5x5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
